// File: rtl/vcve2_dmem_responder.sv
// Data-memory responder: word-addressed SRAM model behind the req/gnt/rvalid
// protocol with byte enables, a fixed response latency, grant throttling and
// out-of-range error responses.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   data_req_i        request valid (held by the master until granted)
//   data_gnt_o        combinational grant
//   data_we_i         1 = write, 0 = read
//   data_be_i         byte enables, bit i covers wdata[8i+7:8i]
//   data_addr_i       byte address, bits [1:0] ignored
//   data_wdata_i      write data
//   data_rvalid_o     response valid, one cycle per granted transaction
//   data_rdata_o      read data (0 for writes, errors and idle cycles)
//   data_err_o        out-of-range flag, valid with rvalid
//   stall_i           throttle, 1 suppresses grant
//   outstanding_o     granted transactions not yet responded
module vcve2_dmem_responder #(
  parameter int unsigned MemWords    = 1024,
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int unsigned RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        stall_i,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned CntW = 4;

  logic [31:0]     mem [MemWords];

  logic [32:0]     addr_diff;
  logic [29:0]     word_off;
  logic [IdxW-1:0] idx;
  logic            in_range;
  logic [1:0]      unused_addr_lsb;

  logic [31:0]     rd_word;
  logic [31:0]     wr_word;
  logic [31:0]     s0_rdata;
  logic            s0_err;

  logic [RespLatency-1:0] pipe_valid;
  logic [RespLatency-1:0] pipe_err;
  logic [31:0]            pipe_rdata [RespLatency];

  logic [CntW-1:0] cnt_next;

  // Address decode; the 33-bit subtraction exposes the below-base borrow.
  assign addr_diff       = {1'b0, data_addr_i} - {1'b0, BaseAddr};
  assign word_off        = addr_diff[31:2];
  assign idx             = word_off[IdxW-1:0];
  assign in_range        = !addr_diff[32] && (32'(word_off) < 32'(MemWords));
  assign unused_addr_lsb = addr_diff[1:0];

  // Grant blocks once every pipeline slot is owned by an unretired response.
  assign data_gnt_o = data_req_i && !stall_i && (32'(outstanding_o) < 32'(RespLatency));

  // Current word and its byte-merged write image.
  always_comb begin
    rd_word = mem[idx];
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (data_be_i[b]) begin
        wr_word[8*b +: 8] = data_wdata_i[8*b +: 8];
      end
    end
  end

  // Storage write port; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (data_gnt_o && data_we_i && in_range) begin
      mem[idx] <= wr_word;
    end
  end

  // Response payload captured on the grant edge.
  always_comb begin
    s0_rdata = '0;
    s0_err   = 1'b0;
    if (!in_range) begin
      s0_err = 1'b1;
    end else if (!data_we_i) begin
      s0_rdata = rd_word;
    end
  end

  // Fixed-latency response shift register; empty stages carry zeros so the
  // outputs read 0 whenever rvalid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RespLatency; i++) begin
        pipe_rdata[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= data_gnt_o;
      pipe_err[0]   <= data_gnt_o && s0_err;
      pipe_rdata[0] <= data_gnt_o ? s0_rdata : 32'h0;
      for (int i = 1; i < RespLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  assign data_rvalid_o = pipe_valid[RespLatency-1];
  assign data_err_o    = pipe_err[RespLatency-1];
  assign data_rdata_o  = pipe_rdata[RespLatency-1];

  // Outstanding count: +1 per grant, -1 per response, hold when both.
  always_comb begin
    cnt_next = outstanding_o;
    case ({data_gnt_o, data_rvalid_o})
      2'b10:   cnt_next = outstanding_o + CntW'(1);
      2'b01:   cnt_next = outstanding_o - CntW'(1);
      default: cnt_next = outstanding_o;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
    end else begin
      outstanding_o <= cnt_next;
    end
  end

endmodule

// File: tb/tb_vcve2_dmem_responder.sv
// Directed bench for vcve2_dmem_responder (RespLatency=2, MemWords=1024).
// A negedge monitor keeps a reference memory, a grant/outstanding model and
// a response scoreboard; the initial block drives the directed sequence.
module tb_vcve2_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        stall_i;
  logic [3:0]  outstanding_o;

  vcve2_dmem_responder #(
    .MemWords    (WORDS),
    .BaseAddr    (BASE),
    .RespLatency (LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .stall_i       (stall_i),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [WORDS];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          exp_out  = 0;

  logic        m_gnt;
  exp_t        m_e;
  logic [32:0] m_diff;
  logic        m_inr;
  int          m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb.delete();
      exp_out = 0;
    end else begin
      m_gnt = data_req_i && !stall_i && (exp_out < int'(LAT));
      chk("gnt", 32'(data_gnt_o), 32'(m_gnt));
      chk("outstanding", 32'(outstanding_o), 32'(exp_out));
      if (data_rvalid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'(data_rvalid_o), 32'd0);
        end else begin
          m_e = sb.pop_front();
          chk("rdata", data_rdata_o, m_e.rdata);
          chk("err", 32'(data_err_o), 32'(m_e.err));
          chk("resp_cycle", 32'(cyc), 32'(m_e.due));
        end
      end else begin
        chk("idle_rdata", data_rdata_o, 32'h0);
        chk("idle_err", 32'(data_err_o), 32'h0);
      end
      if (m_gnt) begin
        m_diff  = {1'b0, data_addr_i} - {1'b0, BASE};
        m_inr   = !m_diff[32] && (m_diff[31:2] < 30'(WORDS));
        m_idx   = int'(m_diff[31:2]);
        m_e.due   = cyc + int'(LAT);
        m_e.rdata = 32'h0;
        m_e.err   = !m_inr;
        if (m_inr) begin
          if (data_we_i) begin
            for (int b = 0; b < 4; b++) begin
              if (data_be_i[b]) model[m_idx][8*b +: 8] = data_wdata_i[8*b +: 8];
            end
          end else begin
            m_e.rdata = model[m_idx];
          end
        end
        sb.push_back(m_e);
      end
      exp_out = exp_out + (m_gnt ? 1 : 0) - (data_rvalid_o ? 1 : 0);
    end
  end

  // Present a request and hold it until granted; returns just after the grant edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    logic got;
    got          = 1'b0;
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_wdata_i = wd;
    data_be_i    = be;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (data_gnt_o) got = 1'b1;
    end
    if (got) begin
      @(posedge clk_i);
      #1;
    end else begin
      chk("grant_timeout", 32'(got), 32'd1);
      data_req_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    data_req_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    stall_i      = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_rvalid", 32'(data_rvalid_o), 32'h0);
    chk("rst_rdata", data_rdata_o, 32'h0);
    chk("rst_err", 32'(data_err_o), 32'h0);
    chk("rst_outstanding", 32'(outstanding_o), 32'h0);
    rst_ni = 1'b1;
    idle(2);

    // Write then read the same word back-to-back.
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    idle(4);

    // Partial write over a full word.
    issue(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    issue(1'b1, 32'h20, 32'h1122_3344, 4'b0101);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    idle(4);

    // Last word, then out-of-range read and write, then last word again.
    issue(1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 32'h1000, 32'h0, 4'hF);
    issue(1'b1, 32'h1004, 32'h1234_5678, 4'hF);
    issue(1'b0, 32'hFFC, 32'h0, 4'hF);
    idle(4);

    // be=0 write is a no-op.
    issue(1'b1, 32'h10, 32'h0BAD_0BAD, 4'h0);
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    idle(4);

    // Preload then stream four reads, responses in order.
    for (int i = 0; i < 4; i++) issue(1'b1, 32'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) issue(1'b0, 32'(4 * i), 32'h0, 4'hF);
    idle(4);

    // Stall while a response is in flight: no grant, pipeline drains.
    issue(1'b0, 32'h4, 32'h0, 4'hF);
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_addr_i = 32'h8;
    stall_i     = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("stall_gnt", 32'(data_gnt_o), 32'h0);
    chk("stall_drained", 32'(outstanding_o), 32'h0);
    @(posedge clk_i);
    #1;
    stall_i = 1'b0;
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    idle(4);

    // Reset with a read in flight; the earlier write must survive.
    issue(1'b1, 32'h40, 32'h5A5A_1234, 4'hF);
    issue(1'b0, 32'h40, 32'h0, 4'hF);
    rst_ni     = 1'b0;
    data_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_outstanding", 32'(outstanding_o), 32'h0);
    chk("post_rst_rvalid", 32'(data_rvalid_o), 32'h0);
    idle(5);
    issue(1'b0, 32'h40, 32'h0, 4'hF);

    idle(10);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
